imem_loader: RTL and testbench

- Writer side of the instruction memory. The CPU fetch path is the reader.
- Receives a program image as a byte stream (valid/ready) from the UART/debug front end.
- Assembles bytes into 32-bit big-endian words and issues word writes into a writable instruction memory, starting at byte address 0.
- Holds the CPU in stall until a complete, legal image has been written.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and loader FSM state type for the instruction memory path
package cpu_pkg;
    localparam int IMEM_DEPTH = 128;
    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } imem_ld_state_t;
endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - big-endian shift assembly of four stream bytes into one word
import cpu_pkg::*;

module byte_packer (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic [1:0]        o_byte_idx,
    output logic              o_word_valid
);
    logic [WORD_W-1:0] r_shift;
    logic [1:0]        r_idx;

    // o_word already includes the byte on the bus, so a completed word is usable on its accept edge
    assign o_word       = {r_shift[WORD_W-BYTE_W-1:0], i_byte};
    assign o_byte_idx   = r_idx;
    assign o_word_valid = i_accept && (r_idx == 2'd3);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_accept) begin
            r_shift <= o_word;
            r_idx   <= r_idx + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader into instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum word
import cpu_pkg::*;

module imem_loader #(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [BYTE_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_mem_write,
    output logic [WORD_W-1:0] o_mem_address,
    output logic [WORD_W-1:0] o_mem_write_data,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam imem_ld_state_t ST_AFTER_DATA = ST_CHK;
`else
    localparam imem_ld_state_t ST_AFTER_DATA = ST_DONE;
`endif

    imem_ld_state_t    r_state, w_next_state;
    logic [CNT_W-1:0]  r_word_idx, r_word_count;
    logic [WORD_W-1:0] w_word;
    logic [1:0]        w_byte_idx;
    logic              w_word_valid, w_word_done, w_accept, w_last_word;
    logic              w_clear, w_hdr_load, w_data_write;

    assign w_accept    = i_rx_valid && o_rx_ready;
    assign w_word_done = w_word_valid && (w_byte_idx == 2'd3);
    assign w_last_word = (r_word_idx == r_word_count - CNT_W'(1));

    byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_clear),
        .i_accept    (w_accept),
        .i_byte      (i_rx_data),
        .o_word      (w_word),
        .o_byte_idx  (w_byte_idx),
        .o_word_valid(w_word_valid)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
        end else if (w_clear) begin
            r_sum <= '0;
        end else if (w_data_write) begin
            r_sum <= r_sum + w_word;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_hdr_load   = 1'b0;
        w_data_write = 1'b0;
        o_rx_ready   = 1'b0;
        o_cpu_hold   = 1'b1;
        o_done       = 1'b0;
        o_error      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_HDR;
                    w_clear      = 1'b1;
                end
            end
            ST_HDR: begin
                o_rx_ready = 1'b1;
                if (w_word_done) begin
                    if (w_word > WORD_W'(DEPTH)) begin
                        w_next_state = ST_ERR;
                    end else if (w_word == '0) begin
                        w_next_state = ST_AFTER_DATA;
                    end else begin
                        w_next_state = ST_DATA;
                        w_hdr_load   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                o_rx_ready = 1'b1;
                if (w_word_done) begin
                    w_data_write = 1'b1;
                    if (w_last_word) begin
                        w_next_state = ST_AFTER_DATA;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                o_rx_ready = 1'b1;
                if (w_word_done) begin
                    w_next_state = (w_word == r_sum) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: begin
                o_cpu_hold = 1'b0;
                o_done     = 1'b1;
                if (i_start) begin
                    w_next_state = ST_HDR;
                    w_clear      = 1'b1;
                end
            end
            ST_ERR: begin
                o_error = 1'b1;
                if (i_start) begin
                    w_next_state = ST_HDR;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Index stops on the last word so the address can never step past the top of memory
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_write      <= 1'b0;
            o_mem_address    <= '0;
            o_mem_write_data <= '0;
            r_word_idx       <= '0;
            r_word_count     <= '0;
        end else begin
            o_mem_write <= w_data_write;
            if (w_clear) begin
                r_word_idx   <= '0;
                r_word_count <= '0;
            end
            if (w_hdr_load) begin
                r_word_count <= w_word[CNT_W-1:0];
            end
            if (w_data_write) begin
                o_mem_address    <= WORD_W'({r_word_idx, 2'b00});
                o_mem_write_data <= w_word;
                if (!w_last_word) begin
                    r_word_idx <= r_word_idx + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader; IMEM_LOADER_CHECKSUM_EN selects checksum-trailer images
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        o_rx_ready, o_mem_write, o_cpu_hold, o_done, o_error;
    logic [31:0] o_mem_address, o_mem_write_data;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_rx_data       (rx_data),
        .i_rx_valid      (rx_valid),
        .o_rx_ready      (o_rx_ready),
        .o_mem_write     (o_mem_write),
        .o_mem_address   (o_mem_address),
        .o_mem_write_data(o_mem_write_data),
        .o_cpu_hold      (o_cpu_hold),
        .o_done          (o_done),
        .o_error         (o_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected (address, data) pair
    always @(negedge clk) begin
        if (rst_n && o_mem_write) begin
            logic [63:0] e;
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         o_mem_address, o_mem_write_data);
            end else begin
                e = exp_q.pop_front();
                if ({o_mem_address, o_mem_write_data} !== e) begin
                    errors++;
                    $display("FAIL mem_write: got addr %h data %h expected addr %h data %h",
                             o_mem_address, o_mem_write_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_ready);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!o_rx_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!o_rx_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got rx_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (chk_ready) check("rx_ready_gap", {31'b0, o_rx_ready}, 32'd1);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit last);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], gap, !(last && i == 3));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Streams header, every word of img and (checksum build) the sum trailer; queues expected writes
    task automatic load_img(input int gap);
        logic [31:0] sum = 32'h0;
        for (int i = 0; i < img.size(); i++) begin
            exp_q.push_back({32'(i * 4), img[i]});
            sum += img[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'(img.size()), gap, 1'b0);
        for (int i = 0; i < img.size(); i++) send_word(img[i], gap, 1'b0);
        send_word(sum, gap, 1'b1);
`else
        send_word(32'(img.size()), gap, img.size() == 0);
        for (int i = 0; i < img.size(); i++) send_word(img[i], gap, i == img.size() - 1);
`endif
    endtask

    task automatic expect_done(input string tag, input int wr_before, input int wr_count);
        @(negedge clk);
        check({tag, "_done"}, {31'b0, o_done}, 32'd1);
        check({tag, "_cpu_hold"}, {31'b0, o_cpu_hold}, 32'd0);
        check({tag, "_rx_ready"}, {31'b0, o_rx_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_writes"}, 32'(n_writes - wr_before), 32'(wr_count));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", {31'b0, o_rx_ready}, 32'd0);
        check("rst_mem_write", {31'b0, o_mem_write}, 32'd0);
        check("rst_mem_address", o_mem_address, 32'd0);
        check("rst_mem_write_data", o_mem_write_data, 32'd0);
        check("rst_cpu_hold", {31'b0, o_cpu_hold}, 32'd1);
        check("rst_done", {31'b0, o_done}, 32'd0);
        check("rst_error", {31'b0, o_error}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_rx_ready", {31'b0, o_rx_ready}, 32'd0);

        // Basic two-word image, continuous stream
        pulse_start();
        check("hdr_rx_ready", {31'b0, o_rx_ready}, 32'd1);
        img = '{32'h34040000, 32'h08000004};
        w0 = n_writes;
        load_img(0);
        expect_done("basic", w0, 2);

        // Throttled restart from DONE
        pulse_start();
        check("restart_done_clear", {31'b0, o_done}, 32'd0);
        check("restart_cpu_hold", {31'b0, o_cpu_hold}, 32'd1);
        w0 = n_writes;
        load_img(3);
        expect_done("throttled", w0, 2);

        // Oversize header
        pulse_start();
        w0 = n_writes;
        send_word(32'h00000081, 0, 1'b1);
        @(negedge clk);
        check("oversize_error", {31'b0, o_error}, 32'd1);
        check("oversize_cpu_hold", {31'b0, o_cpu_hold}, 32'd1);
        check("oversize_rx_ready", {31'b0, o_rx_ready}, 32'd0);
        check("oversize_writes", 32'(n_writes - w0), 32'd0);

        // Zero-length image, then restart with a normal image
        pulse_start();
        check("restart_err_clear", {31'b0, o_error}, 32'd0);
        img = '{};
        w0 = n_writes;
        load_img(0);
        expect_done("zero_len", w0, 0);
        pulse_start();
        check("zero_restart_done", {31'b0, o_done}, 32'd0);
        check("zero_restart_hold", {31'b0, o_cpu_hold}, 32'd1);
        img = '{32'h34040000, 32'h08000004};
        w0 = n_writes;
        load_img(0);
        expect_done("after_zero", w0, 2);

        // Full-depth image: last write must land at 0x1FC
        pulse_start();
        img = '{};
        for (int i = 0; i < 128; i++) img.push_back(32'hA5000000 | 32'(i));
        w0 = n_writes;
        load_img(0);
        expect_done("full_depth", w0, 128);
        check("full_depth_last_addr", o_mem_address, 32'h000001FC);
        check("full_depth_last_data", o_mem_write_data, 32'hA500007F);

        // Asynchronous reset after five data bytes
        pulse_start();
        send_word(32'h00000002, 0, 1'b0);
        exp_q.push_back({32'h0, 32'h11223344});
        send_word(32'h11223344, 0, 1'b0);
        send_byte(8'h55, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rx_ready", {31'b0, o_rx_ready}, 32'd0);
        check("async_mem_write", {31'b0, o_mem_write}, 32'd0);
        check("async_cpu_hold", {31'b0, o_cpu_hold}, 32'd1);
        check("async_done", {31'b0, o_done}, 32'd0);
        check("async_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        img = '{32'hCAFEF00D, 32'h0BADBEEF};
        w0 = n_writes;
        load_img(0);
        expect_done("post_reset", w0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Sum wraps to zero: good trailer, then a wrong one
        pulse_start();
        exp_q.push_back({32'h0, 32'h00000001});
        exp_q.push_back({32'h4, 32'hFFFFFFFF});
        w0 = n_writes;
        send_word(32'h2, 0, 1'b0);
        send_word(32'h00000001, 0, 1'b0);
        send_word(32'hFFFFFFFF, 0, 1'b0);
        send_word(32'h00000000, 0, 1'b1);
        expect_done("chk_good", w0, 2);
        pulse_start();
        exp_q.push_back({32'h0, 32'h00000001});
        exp_q.push_back({32'h4, 32'hFFFFFFFF});
        w0 = n_writes;
        send_word(32'h2, 0, 1'b0);
        send_word(32'h00000001, 0, 1'b0);
        send_word(32'hFFFFFFFF, 0, 1'b0);
        send_word(32'h00000001, 0, 1'b1);
        @(negedge clk);
        check("chk_bad_error", {31'b0, o_error}, 32'd1);
        check("chk_bad_done", {31'b0, o_done}, 32'd0);
        check("chk_bad_cpu_hold", {31'b0, o_cpu_hold}, 32'd1);
        check("chk_bad_writes", 32'(n_writes - w0), 32'd2);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
